multi_cycle_ctrl: RTL and testbench
===================================

// Module: multi_cycle_ctrl
// PURPOSE
//  Main control FSM for the multi-cycle MIPS datapath (shared ALU, single unified memory, IR/MDR/A/B/ALUOut regs).
//  Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB. Drives every mux select, register enable and memory strobe.
//  Stalls on a memory ready handshake. Keeps cycle and retired-instruction counters. Halts on an illegal opcode.
// PARAMETERS
//  CNT_W   32  width of cycle_cnt_o and retired_cnt_o
// PORTS
//  clk_i          in   1      clock; all state updates on rising edge
//  rst_i          in   1      reset, asynchronous, active-low
//  op_i           in   6      opcode, IR[31:26]
//  zero_i         in   1      ALU Zero flag
//  mem_ready_i    in   1      memory has completed the current read/write this cycle
//  iord_o         out  1      memory address mux: 0=PC, 1=ALUOut
//  mem_read_o     out  1      memory read strobe; held until mem_ready_i
//  mem_write_o    out  1      memory write strobe; held until mem_ready_i
//  ir_write_o     out  1      IR load enable
//  reg_dst_o      out  1      write reg: 0=rt, 1=rd
//  mem_to_reg_o   out  1      write data: 0=ALUOut, 1=MDR
//  reg_write_o    out  1      register file write enable
//  alu_src_a_o    out  1      ALU A: 0=PC, 1=A reg
//  alu_src_b_o    out  2      ALU B: 00=B reg, 01=4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op_o       out  3      000 add, 001 sub, 010 use funct, 011 slt
//  pc_src_o       out  2      next PC: 00=ALU result, 01=ALUOut, 10=jump target
//  pc_en_o        out  1      PC load enable
//  retire_o       out  1      one-cycle pulse on the last cycle of each instruction
//  halted_o       out  1      sticky; illegal opcode seen
//  cycle_cnt_o    out  CNT_W  clock cycles since reset, excluding HALT
//  retired_cnt_o  out  CNT_W  count of retire_o pulses
// BEHAVIOUR
//  Reset (rst_i=0, async): state=FETCH. Counters=0. halted_o=0. All strobes and enables=0, all selects=0.
//  Opcodes: R=000000, LW=100011, SW=101011, BEQ=000100, BNE=000101, ADDI=001000, SLTI=001010, J=000010.
//  Outputs are Moore on state, except pc_en_o/ir_write_o (gated by mem_ready_i) and pc_en_o in BRANCH (gated by zero_i).
//  FETCH: iord=0, mem_read=1, srcA=0, srcB=01, alu_op=000, pc_src=00.
//    If mem_ready_i=1: ir_write=1 and pc_en=1 (PC<=PC+4), go to DECODE. Else stay, no side effects.
//  DECODE: srcA=0, srcB=11, alu_op=000 (branch target into ALUOut). Dispatch on op_i:
//    LW/SW->MEM_ADDR, R->R_EXEC, ADDI/SLTI->I_EXEC, BEQ/BNE->BRANCH, J->JUMP, other->HALT.
//  MEM_ADDR: srcA=1, srcB=10, alu_op=000. Go to MEM_READ if LW, else MEM_WRITE.
//  MEM_READ: iord=1, mem_read=1. On mem_ready_i go to MEM_WB, else stay.
//  MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, retire; next FETCH.
//  MEM_WRITE: iord=1, mem_write=1. On mem_ready_i: retire, next FETCH. Else stay.
//  R_EXEC: srcA=1, srcB=00, alu_op=010; next R_WB. R_WB: reg_dst=1, mem_to_reg=0, reg_write=1, retire; next FETCH.
//  I_EXEC: srcA=1, srcB=10, alu_op=000 (ADDI) or 011 (SLTI); next I_WB.
//  I_WB: reg_dst=0, mem_to_reg=0, reg_write=1, retire; next FETCH.
//  BRANCH: srcA=1, srcB=00, alu_op=001, pc_src=01. pc_en = zero_i for BEQ, ~zero_i for BNE. Retire; next FETCH.
//  JUMP: pc_src=10, pc_en=1, retire; next FETCH.
//  HALT: absorbing until reset. halted_o=1, all strobes/enables 0. Counters frozen. No retire.
//  op_i is sampled in DECODE and MEM_ADDR/I_EXEC/BRANCH only (IR stable there). Latched copy not required.
//  Counters: cycle_cnt +1 every non-HALT cycle. retired_cnt +1 per retire_o. Both wrap modulo 2^CNT_W, no saturation.
//  mem_read_o/mem_write_o never both 1. Strobe stays high continuously across stall cycles.
//  Reset asserted mid-instruction: immediate return to FETCH. Partially done writes are not completed.
//  Deassertion takes effect at the next clock edge.
// TESTING
//  1. mem_ready_i=1 always; R-type add: FETCH,DECODE,R_EXEC,R_WB. 4 cycles, retire on 4th, reg_write=1, reg_dst=1. retired_cnt=1.
//  2. LW with mem_ready_i low 3 cycles in MEM_READ: mem_read_o held 4 cycles, iord=1, no reg_write until MEM_WB. Total 8 cycles.
//  3. BEQ, zero_i=1 -> pc_en=1, pc_src=01. BNE, zero_i=1 -> pc_en=0. Both retire after 3 cycles.
//  4. op_i=111111 in DECODE -> HALT, halted_o=1. Counters frozen for 10 cycles. rst_i low -> FETCH, counters 0.
//  5. rst_i pulsed low mid-MEM_WRITE: mem_write_o drops same cycle (async). FETCH after release, retired_cnt=0.
//  6. CNT_W=4: run 16 single-cycle-ready J instructions -> retired_cnt_o wraps to 0, cycle_cnt_o = 48 mod 16 = 0.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM for a multi-cycle MIPS datapath: sequences fetch/decode/execute/mem/writeback,
// stalls on the memory handshake, counts cycles and retired instructions, halts on illegal opcodes.
module multi_cycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       op_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             iord_o,
  output logic             mem_read_o,
  output logic             mem_write_o,
  output logic             ir_write_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic [1:0]       pc_src_o,
  output logic             pc_en_o,
  output logic             retire_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] retired_cnt_o
);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpSlti = 6'b001010;
  localparam logic [5:0] OpJ    = 6'b000010;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAddr, StMemRead, StMemWb, StMemWrite, StRExec,
    StRWb, StIExec, StIWb, StBranch, StJump, StHalt
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, retired_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_q   <= '0;
      retired_cnt_q <= '0;
    end else begin
      if (state_q != StHalt) cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (retire_o) retired_cnt_q <= retired_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:    if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        unique case (op_i)
          OpLw, OpSw:     state_d = StMemAddr;
          OpR:            state_d = StRExec;
          OpAddi, OpSlti: state_d = StIExec;
          OpBeq, OpBne:   state_d = StBranch;
          OpJ:            state_d = StJump;
          default:        state_d = StHalt;
        endcase
      end
      StMemAddr:  state_d = (op_i == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready_i) state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: if (mem_ready_i) state_d = StFetch;
      StRExec:    state_d = StRWb;
      StRWb:      state_d = StFetch;
      StIExec:    state_d = StIWb;
      StIWb:      state_d = StFetch;
      StBranch:   state_d = StFetch;
      StJump:     state_d = StFetch;
      StHalt:     state_d = StHalt;
      default:    state_d = StFetch;
    endcase
  end

  // Outputs are forced idle while reset is held so an in-flight write strobe drops at once.
  always_comb begin
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    reg_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 3'b000;
    pc_src_o     = 2'b00;
    pc_en_o      = 1'b0;
    retire_o     = 1'b0;
    halted_o     = 1'b0;
    if (rst_i) begin
      unique case (state_q)
        StFetch: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = 2'b01;
          ir_write_o  = mem_ready_i;
          pc_en_o     = mem_ready_i;
        end
        StDecode:  alu_src_b_o = 2'b11;
        StMemAddr: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
        end
        StMemRead: begin
          iord_o     = 1'b1;
          mem_read_o = 1'b1;
        end
        StMemWb: begin
          mem_to_reg_o = 1'b1;
          reg_write_o  = 1'b1;
          retire_o     = 1'b1;
        end
        StMemWrite: begin
          iord_o      = 1'b1;
          mem_write_o = 1'b1;
          retire_o    = mem_ready_i;
        end
        StRExec: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 3'b010;
        end
        StRWb: begin
          reg_dst_o   = 1'b1;
          reg_write_o = 1'b1;
          retire_o    = 1'b1;
        end
        StIExec: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = 2'b10;
          alu_op_o    = (op_i == OpSlti) ? 3'b011 : 3'b000;
        end
        StIWb: begin
          reg_write_o = 1'b1;
          retire_o    = 1'b1;
        end
        StBranch: begin
          alu_src_a_o = 1'b1;
          alu_op_o    = 3'b001;
          pc_src_o    = 2'b01;
          pc_en_o     = (op_i == OpBne) ? ~zero_i : zero_i;
          retire_o    = 1'b1;
        end
        StJump: begin
          pc_src_o = 2'b10;
          pc_en_o  = 1'b1;
          retire_o = 1'b1;
        end
        StHalt:  halted_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign cycle_cnt_o   = cycle_cnt_q;
  assign retired_cnt_o = retired_cnt_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle control vectors, halt, async reset and counter wrap.
module tb_multi_cycle_ctrl;

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpAddi = 6'b001000;
  localparam logic [5:0] OpSlti = 6'b001010, OpJ = 6'b000010, OpBad = 6'b111111;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [5:0]  op_i = '0;
  logic        zero_i = 1'b0, mem_ready_i = 1'b0;
  logic        iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b, pc_src;
  logic [2:0]  alu_op;
  logic        pc_en, retire, halted;
  logic [31:0] cycle_cnt, retired_cnt;

  logic        rst4 = 1'b0;
  logic        iord4, mrd4, mwr4, irw4, rdst4, m2r4, rw4, sa4, pcen4, ret4, hlt4;
  logic [1:0]  sb4, ps4;
  logic [2:0]  aop4;
  logic [3:0]  cyc4, ret_cnt4;

  always #5 clk = ~clk;

  multi_cycle_ctrl #(.CNT_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .zero_i(zero_i), .mem_ready_i(mem_ready_i),
    .iord_o(iord), .mem_read_o(mem_read), .mem_write_o(mem_write), .ir_write_o(ir_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .reg_write_o(reg_write),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .pc_src_o(pc_src),
    .pc_en_o(pc_en), .retire_o(retire), .halted_o(halted), .cycle_cnt_o(cycle_cnt),
    .retired_cnt_o(retired_cnt)
  );

  multi_cycle_ctrl #(.CNT_W(4)) u_dut4 (
    .clk_i(clk), .rst_i(rst4), .op_i(OpJ), .zero_i(1'b0), .mem_ready_i(1'b1),
    .iord_o(iord4), .mem_read_o(mrd4), .mem_write_o(mwr4), .ir_write_o(irw4),
    .reg_dst_o(rdst4), .mem_to_reg_o(m2r4), .reg_write_o(rw4), .alu_src_a_o(sa4),
    .alu_src_b_o(sb4), .alu_op_o(aop4), .pc_src_o(ps4), .pc_en_o(pcen4), .retire_o(ret4),
    .halted_o(hlt4), .cycle_cnt_o(cyc4), .retired_cnt_o(ret_cnt4)
  );

  logic [17:0] act_ctl;
  assign act_ctl = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                    alu_src_a, alu_src_b, alu_op, pc_src, pc_en, retire, halted};

  function automatic logic [17:0] ctl(input logic io, mr, mw, irw, rd, m2r, rw, sa,
                                      input logic [1:0] sb, input logic [2:0] aop,
                                      input logic [1:0] ps, input logic pe, rt, ht);
    return {io, mr, mw, irw, rd, m2r, rw, sa, sb, aop, ps, pe, rt, ht};
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          n_checks = 0, n_fail = 0;
  logic [31:0] exp_cycles = 0, exp_retired = 0;

  logic [17:0] e_fetch, e_fstall, e_decode, e_rexec, e_rwb, e_maddr, e_mread, e_mwb;
  logic [17:0] e_mwr_st, e_mwr, e_slti, e_iwb, e_br_t, e_br_n, e_jump, e_halt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic z, input logic r, input logic [17:0] e);
    vecs.push_back('{op: op, zero: z, rdy: r, exp: e});
  endtask

  // One clock of stimulus: drive at negedge, check outputs and counters shortly after.
  task automatic step(input logic [5:0] op, input logic z, input logic r, input logic [17:0] e,
                      input string name);
    @(negedge clk);
    rst_i = 1'b1;
    op_i = op;
    zero_i = z;
    mem_ready_i = r;
    #1;
    chk({name, " ctl"}, 32'(act_ctl), 32'(e));
    chk({name, " strobe excl"}, 32'(mem_read & mem_write), 32'd0);
    chk({name, " cycle_cnt"}, cycle_cnt, exp_cycles);
    chk({name, " retired_cnt"}, retired_cnt, exp_retired);
    if (!e[0]) exp_cycles++;
    if (e[1]) exp_retired++;
  endtask

  initial begin
    e_fetch  = ctl(0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 1, 0, 0);
    e_fstall = ctl(0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0, 0, 0);
    e_decode = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 3'b000, 2'b00, 0, 0, 0);
    e_rexec  = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b010, 2'b00, 0, 0, 0);
    e_rwb    = ctl(0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0);
    e_maddr  = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0, 0, 0);
    e_mread  = ctl(1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
    e_mwb    = ctl(0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0);
    e_mwr_st = ctl(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 0);
    e_mwr    = ctl(1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0);
    e_slti   = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b011, 2'b00, 0, 0, 0);
    e_iwb    = ctl(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 3'b000, 2'b00, 0, 1, 0);
    e_br_t   = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 1, 1, 0);
    e_br_n   = ctl(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 0, 1, 0);
    e_jump   = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 1, 1, 0);
    e_halt   = ctl(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0, 0, 1);

    // R-type, LW with three stall cycles, branches both ways, SW with stalls, ADDI, SLTI, J
    add(OpR, 0, 1, e_fetch);    add(OpR, 0, 1, e_decode);
    add(OpR, 0, 1, e_rexec);    add(OpR, 0, 1, e_rwb);
    add(OpLw, 0, 1, e_fetch);   add(OpLw, 0, 1, e_decode);  add(OpLw, 0, 1, e_maddr);
    add(OpLw, 0, 0, e_mread);   add(OpLw, 0, 0, e_mread);   add(OpLw, 0, 0, e_mread);
    add(OpLw, 0, 1, e_mread);   add(OpLw, 0, 1, e_mwb);
    add(OpBeq, 1, 1, e_fetch);  add(OpBeq, 1, 1, e_decode); add(OpBeq, 1, 1, e_br_t);
    add(OpBne, 1, 1, e_fetch);  add(OpBne, 1, 1, e_decode); add(OpBne, 1, 1, e_br_n);
    add(OpBeq, 0, 1, e_fetch);  add(OpBeq, 0, 1, e_decode); add(OpBeq, 0, 1, e_br_n);
    add(OpBne, 0, 1, e_fetch);  add(OpBne, 0, 1, e_decode); add(OpBne, 0, 1, e_br_t);
    add(OpSw, 0, 0, e_fstall);  add(OpSw, 0, 1, e_fetch);   add(OpSw, 0, 1, e_decode);
    add(OpSw, 0, 1, e_maddr);   add(OpSw, 0, 0, e_mwr_st);  add(OpSw, 0, 1, e_mwr);
    add(OpAddi, 0, 1, e_fetch); add(OpAddi, 0, 1, e_decode);
    add(OpAddi, 0, 1, e_maddr); add(OpAddi, 0, 1, e_iwb);
    add(OpSlti, 0, 1, e_fetch); add(OpSlti, 0, 1, e_decode);
    add(OpSlti, 0, 1, e_slti);  add(OpSlti, 0, 1, e_iwb);
    add(OpJ, 0, 1, e_fetch);    add(OpJ, 0, 1, e_decode);   add(OpJ, 0, 1, e_jump);

    #1;
    chk("reset ctl", 32'(act_ctl), 32'd0);
    chk("reset cycle_cnt", cycle_cnt, 32'd0);
    chk("reset retired_cnt", retired_cnt, 32'd0);

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].op, vecs[i].zero, vecs[i].rdy, vecs[i].exp, $sformatf("vec%0d", i));

    // Illegal opcode: halt and freeze counters for 10 cycles
    step(OpBad, 0, 1, e_fetch, "bad fetch");
    step(OpBad, 0, 1, e_decode, "bad decode");
    for (int i = 0; i < 10; i++) step(OpR, 0, 1, e_halt, $sformatf("halt%0d", i));

    @(negedge clk);
    rst_i = 1'b0;
    #1;
    chk("halt reset ctl", 32'(act_ctl), 32'd0);
    chk("halt reset cycle_cnt", cycle_cnt, 32'd0);
    chk("halt reset retired_cnt", retired_cnt, 32'd0);
    exp_cycles = 0;
    exp_retired = 0;

    // Reset pulsed mid-MEM_WRITE: strobe drops immediately, write never retires
    step(OpSw, 0, 1, e_fetch, "sw2 fetch");
    step(OpSw, 0, 1, e_decode, "sw2 decode");
    step(OpSw, 0, 1, e_maddr, "sw2 maddr");
    step(OpSw, 0, 0, e_mwr_st, "sw2 mwr");
    #2;
    rst_i = 1'b0;
    #1;
    chk("async rst ctl", 32'(act_ctl), 32'd0);
    chk("async rst cycle_cnt", cycle_cnt, 32'd0);
    chk("async rst retired_cnt", retired_cnt, 32'd0);
    exp_cycles = 0;
    exp_retired = 0;
    step(OpJ, 0, 1, e_fetch, "post rst fetch");
    step(OpJ, 0, 1, e_decode, "post rst decode");
    step(OpJ, 0, 1, e_jump, "post rst jump");
    step(OpJ, 0, 1, e_fetch, "post rst fetch2");

    // 4-bit counters: 16 jumps of 3 cycles each wrap both counters to zero
    @(negedge clk);
    rst4 = 1'b1;
    repeat (16) @(negedge clk);
    chk("wrap16 cycle", 32'(cyc4), 32'd0);
    chk("wrap16 retired", 32'(ret_cnt4), 32'd5);
    repeat (8) @(negedge clk);
    chk("wrap24 cycle", 32'(cyc4), 32'd8);
    chk("wrap24 retired", 32'(ret_cnt4), 32'd8);
    repeat (24) @(negedge clk);
    chk("wrap48 cycle", 32'(cyc4), 32'd0);
    chk("wrap48 retired", 32'(ret_cnt4), 32'd0);
    chk("wrap48 fetch ctl", 32'({mrd4, irw4, pcen4, hlt4}), 32'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
